io_input_conditioner: RTL and testbench

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

---
 rtl/io_input_conditioner.sv | 143 ++++++++++++++
 tb/tb_io_input_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// Board input conditioner: 2-flop sync on all inputs, registered switches, per-key debounce FSM.
// Latency: switches 3 edges, keys 2+DEBOUNCE_CYCLES+1 edges; no backpressure (free-running inputs).
module io_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        physical_clock,
   input  logic        n_reset,
   input  logic [17:0] raw_sw,
   input  logic [3:0]  raw_key,
   output logic [21:0] IO_input,
   output logic [3:0]  key_press,
   output logic [3:0]  key_release,
   output logic        sw_changed
);

   // DEBOUNCE_CYCLES must be >= 2
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      IDLE_RELEASED,
      COUNT_PRESS,
      IDLE_PRESSED,
      COUNT_RELEASE
   } key_state_t;

   logic [17:0] sw_meta, sw_sync, sw_q;
   logic [3:0]  key_meta, key_sync;
   logic [3:0]  key_lvl;

   // Key synchronizers reset to 1 so a reset reads as "released"
   always_ff @(posedge physical_clock or negedge n_reset) begin
      if (!n_reset) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= '1;
         key_sync <= '1;
      end else begin
         sw_meta  <= raw_sw;
         sw_sync  <= sw_meta;
         key_meta <= raw_key;
         key_sync <= key_meta;
      end
   end

   always_ff @(posedge physical_clock or negedge n_reset) begin
      if (!n_reset) begin
         sw_q       <= '0;
         sw_changed <= 1'b0;
      end else begin
         sw_q       <= sw_sync;
         sw_changed <= (sw_sync != sw_q);
      end
   end

   assign IO_input = {key_lvl, sw_q};

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_state_t    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lvl_q, lvl_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;
      logic          pressed;

      assign pressed = ~key_sync[k];

      always_ff @(posedge physical_clock or negedge n_reset) begin
         if (!n_reset) begin
            state_q <= IDLE_RELEASED;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      // Acceptance needs the counter at max and one more agreeing sample
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         lvl_d   = lvl_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         case (state_q)
            IDLE_RELEASED: begin
               if (pressed) begin
                  state_d = COUNT_PRESS;
                  cnt_d   = CW'(1);
               end
            end
            COUNT_PRESS: begin
               if (!pressed) begin
                  state_d = IDLE_RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = IDLE_PRESSED;
                  cnt_d   = '0;
                  lvl_d   = 1'b1;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            IDLE_PRESSED: begin
               if (!pressed) begin
                  state_d = COUNT_RELEASE;
                  cnt_d   = CW'(1);
               end
            end
            COUNT_RELEASE: begin
               if (pressed) begin
                  state_d = IDLE_PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = IDLE_RELEASED;
                  cnt_d   = '0;
                  lvl_d   = 1'b0;
                  rel_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE_RELEASED;
               cnt_d   = '0;
               lvl_d   = 1'b0;
            end
         endcase
      end

      assign key_lvl[k]     = lvl_q;
      assign key_press[k]   = press_q;
      assign key_release[k] = rel_q;
   end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
module tb_io_input_conditioner;

   localparam int DEB = 4;

   logic        physical_clock = 1'b0;
   logic        n_reset;
   logic [17:0] raw_sw;
   logic [3:0]  raw_key;
   logic [21:0] IO_input;
   logic [3:0]  key_press;
   logic [3:0]  key_release;
   logic        sw_changed;

   int tests_run    = 0;
   int tests_failed = 0;

   io_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
      .physical_clock (physical_clock),
      .n_reset        (n_reset),
      .raw_sw         (raw_sw),
      .raw_key        (raw_key),
      .IO_input       (IO_input),
      .key_press      (key_press),
      .key_release    (key_release),
      .sw_changed     (sw_changed)
   );

   always #5 physical_clock = ~physical_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge physical_clock);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_reset = 1'b0;
      raw_sw  = '0;
      raw_key = 4'hF;
      tick(3);
      chk("rst_io",      32'(IO_input),    32'h0);
      chk("rst_press",   32'(key_press),   32'h0);
      chk("rst_release", 32'(key_release), 32'h0);
      chk("rst_swchg",   32'(sw_changed),  32'h0);
      n_reset = 1'b1;
      tick(5);
      chk("idle_io", 32'(IO_input), 32'h0);

      // switches: 3-edge latency, single-cycle change pulse
      raw_sw = 18'h00005;
      tick(2);
      chk("sw_e2_io",  32'(IO_input[17:0]), 32'h0);
      chk("sw_e2_chg", 32'(sw_changed),     32'h0);
      tick(1);
      chk("sw_e3_io",  32'(IO_input[17:0]), 32'h5);
      chk("sw_e3_chg", 32'(sw_changed),     32'h1);
      tick(1);
      chk("sw_e4_io",  32'(IO_input[17:0]), 32'h5);
      chk("sw_e4_chg", 32'(sw_changed),     32'h0);
      raw_sw = 18'h3FFFA;
      tick(3);
      chk("sw_all_io",  32'(IO_input[17:0]), 32'h3FFFA);
      chk("sw_all_chg", 32'(sw_changed),     32'h1);
      tick(1);
      chk("sw_all_chg_end", 32'(sw_changed), 32'h0);
      raw_sw = '0;
      tick(4);
      chk("sw_clear_io", 32'(IO_input), 32'h0);

      // key 0 held: accepted on edge 7, no repeat pulse
      raw_key[0] = 1'b0;
      tick(6);
      chk("k0_e6_press", 32'(key_press),   32'h0);
      chk("k0_e6_io",    32'(IO_input[18]), 32'h0);
      tick(1);
      chk("k0_e7_press", 32'(key_press),   32'h1);
      chk("k0_e7_io",    32'(IO_input[18]), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("k0_hold_press", 32'(key_press),    32'h0);
         chk("k0_hold_io",    32'(IO_input[18]), 32'h1);
      end
      raw_key[0] = 1'b1;
      tick(6);
      chk("k0_rel_e6", 32'(key_release), 32'h0);
      tick(1);
      chk("k0_rel_e7",       32'(key_release),  32'h1);
      chk("k0_rel_e7_press", 32'(key_press),    32'h0);
      chk("k0_rel_e7_io",    32'(IO_input[18]), 32'h0);
      tick(1);
      chk("k0_rel_e8", 32'(key_release), 32'h0);

      // key 1 glitch of 3 cycles: nothing happens
      raw_key[1] = 1'b0;
      tick(3);
      raw_key[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("k1_glitch", 32'({IO_input[19], key_press, key_release}), 32'h0);
      end

      // key 2: press, short release glitch ignored, then real release
      raw_key[2] = 1'b0;
      tick(7);
      chk("k2_press",    32'(key_press),    32'h4);
      chk("k2_press_io", 32'(IO_input[20]), 32'h1);
      tick(2);
      raw_key[2] = 1'b1;
      tick(2);
      raw_key[2] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("k2_rel_glitch", 32'({IO_input[20], key_release}), 32'h10);
      end
      raw_key[2] = 1'b1;
      tick(6);
      chk("k2_rel_e6", 32'(key_release), 32'h0);
      tick(1);
      chk("k2_rel_e7",    32'(key_release),  32'h4);
      chk("k2_rel_e7_io", 32'(IO_input[20]), 32'h0);
      tick(3);
      chk("k2_rel_after",    32'(key_release),  32'h0);
      chk("k2_rel_after_io", 32'(IO_input[20]), 32'h0);

      // key 3 held through a reset pulsed mid-count
      raw_sw     = 18'h00ABC;
      raw_key[3] = 1'b0;
      tick(4);
      chk("k3_pre_rst_io", 32'(IO_input), 32'h00ABC);
      n_reset = 1'b0;
      #1;
      chk("k3_rst_io",      32'(IO_input),    32'h0);
      chk("k3_rst_press",   32'(key_press),   32'h0);
      chk("k3_rst_release", 32'(key_release), 32'h0);
      chk("k3_rst_swchg",   32'(sw_changed),  32'h0);
      tick(2);
      chk("k3_rst_hold_io", 32'(IO_input), 32'h0);
      n_reset = 1'b1;
      tick(3);
      chk("k3_post_sw_io",  32'(IO_input[17:0]), 32'h00ABC);
      chk("k3_post_sw_chg", 32'(sw_changed),     32'h1);
      tick(3);
      chk("k3_post_e6_press", 32'(key_press),    32'h0);
      chk("k3_post_e6_io",    32'(IO_input[21]), 32'h0);
      tick(1);
      chk("k3_post_e7_press", 32'(key_press), 32'h8);
      chk("k3_post_e7_io",    32'(IO_input),  32'h200ABC);
      tick(1);
      chk("k3_post_e8_press", 32'(key_press), 32'h0);

      // keys 0 and 3 pressed together, then released together with a switch change
      raw_key = 4'hF;
      raw_sw  = '0;
      tick(10);
      chk("multi_idle_io", 32'(IO_input), 32'h0);
      raw_key = 4'b0110;
      tick(6);
      chk("multi_e6_press", 32'(key_press), 32'h0);
      tick(1);
      chk("multi_e7_press", 32'(key_press),       32'h9);
      chk("multi_e7_io",    32'(IO_input[21:18]), 32'h9);
      tick(1);
      chk("multi_e8_press", 32'(key_press), 32'h0);
      raw_key = 4'hF;
      raw_sw  = 18'h20001;
      tick(3);
      chk("multi_sw_chg",  32'(sw_changed),     32'h1);
      chk("multi_sw_io",   32'(IO_input[17:0]), 32'h20001);
      chk("multi_sw_rel",  32'(key_release),    32'h0);
      tick(3);
      chk("multi_rel_e6", 32'(key_release), 32'h0);
      tick(1);
      chk("multi_rel_e7",       32'(key_release),     32'h9);
      chk("multi_rel_e7_press", 32'(key_press),       32'h0);
      chk("multi_rel_e7_io",    32'(IO_input[21:18]), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
